// File: rtl/march_pkg.sv
// Shared widths and FSM state encodings for the invader formation march controller.
package march_pkg;
    localparam int COORD_W  = 11;
    localparam int CALC_W   = 12;
    localparam int PERIOD_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT   = 2'd0;
    localparam state_t ST_MOVE   = 2'd1;
    localparam state_t ST_DROP   = 2'd2;
    localparam state_t ST_LANDED = 2'd3;
endpackage

// File: rtl/frame_divider.sv
// Counts qualified frame strobes and fires a combinational tick on the last frame of a period.
module frame_divider
    import march_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                strobe,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] cnt;
    logic                last;

    // >= rather than == so a period that shrinks below the count cannot stall the march
    assign last = (cnt >= period - PERIOD_W'(1));
    assign tick = strobe && enable && last;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (strobe && enable) begin
            cnt <= last ? '0 : cnt + PERIOD_W'(1);
        end
    end
endmodule

// File: rtl/formation_march_ctrl.sv
// Invader formation sequencer: steps X every N frames, drops and reverses at the bounds, flags landing.
// Optional SPEEDUP_EN shortens the step period by one frame on every drop, floored at MIN_FRAMES.
module formation_march_ctrl
    import march_pkg::*;
#(
    parameter int START_X         = 32,
    parameter int START_Y         = 48,
    parameter int FORM_WIDTH      = 400,
    parameter int FORM_HEIGHT     = 160,
    parameter int LEFT_BOUND      = 0,
    parameter int RIGHT_BOUND     = 639,
    parameter int BOTTOM_LIMIT    = 440,
    parameter int STEP_X          = 4,
    parameter int DROP_Y          = 16,
    parameter int FRAMES_PER_STEP = 30,
    parameter int MIN_FRAMES      = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               restart,
    output logic [COORD_W-1:0] topLeftX,
    output logic [COORD_W-1:0] topLeftY,
    output logic               stepPulse,
    output logic               moveRight,
    output logic               reachedBottom
);
`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam logic signed [CALC_W-1:0] STEP_S    = CALC_W'(STEP_X);
    localparam logic signed [CALC_W-1:0] LEFT_LIM  = CALC_W'(LEFT_BOUND);
    localparam logic signed [CALC_W-1:0] RIGHT_LIM = CALC_W'(RIGHT_BOUND - FORM_WIDTH + 1);
    localparam logic [PERIOD_W-1:0]      PERIOD0   = PERIOD_W'(FRAMES_PER_STEP);
    localparam logic [PERIOD_W-1:0]      PERIOD_MIN = PERIOD_W'(MIN_FRAMES);

    state_t                    state;
    logic [PERIOD_W-1:0]       period;
    logic                      tick;
    logic signed [CALC_W-1:0]  x_s;
    logic signed [CALC_W-1:0]  nx;
    logic                      blocked;
    logic                      landing;

    frame_divider u_div (
        .clk    (clk),
        .resetN (resetN),
        .strobe (startOfFrame),
        .enable (enable && (state == ST_WAIT)),
        .clear  (restart || (state == ST_DROP)),
        .period (period),
        .tick   (tick)
    );

    // Candidate X in a wider signed space so a step past 0 shows up as negative, not a wrap
    assign x_s     = signed'({1'b0, topLeftX});
    assign nx      = moveRight ? (x_s + STEP_S) : (x_s - STEP_S);
    assign blocked = moveRight ? (nx > RIGHT_LIM) : (nx < LEFT_LIM);
    assign landing = ({1'b0, topLeftY} + CALC_W'(DROP_Y) + CALC_W'(FORM_HEIGHT)) >= CALC_W'(BOTTOM_LIMIT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= ST_WAIT;
            topLeftX      <= COORD_W'(START_X);
            topLeftY      <= COORD_W'(START_Y);
            moveRight     <= 1'b1;
            stepPulse     <= 1'b0;
            reachedBottom <= 1'b0;
        end else if (restart) begin
            state         <= ST_WAIT;
            topLeftX      <= COORD_W'(START_X);
            topLeftY      <= COORD_W'(START_Y);
            moveRight     <= 1'b1;
            stepPulse     <= 1'b0;
            reachedBottom <= 1'b0;
        end else begin
            stepPulse <= 1'b0;
            case (state)
                ST_WAIT: if (tick) state <= ST_MOVE;
                ST_MOVE: begin
                    if (blocked) begin
                        state <= ST_DROP;
                    end else begin
                        topLeftX  <= nx[COORD_W-1:0];
                        stepPulse <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    topLeftY  <= topLeftY + COORD_W'(DROP_Y);
                    moveRight <= ~moveRight;
                    stepPulse <= 1'b1;
                    if (landing) begin
                        state         <= ST_LANDED;
                        reachedBottom <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_LANDED: state <= ST_LANDED;
                default:   state <= ST_WAIT;
            endcase
        end
    end

    // Period stays at its reset value unless speed-up is built in
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            period <= PERIOD0;
        end else if (restart) begin
            period <= PERIOD0;
        end else if (SPEEDUP && (state == ST_DROP)) begin
            period <= (period > PERIOD_MIN) ? period - PERIOD_W'(1) : PERIOD_MIN;
        end
    end
endmodule
